vend_arbiter: RTL and testbench

VEND_ARBITER -- requirements
Module: vend_arbiter

---
 rtl/vend_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_vend_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// -----------------------------------------------------------------------------
// vend_arbiter
//
// Two-slot vending session arbiter. One coin slot at a time owns a session:
// the first valid coin grants its slot (round-robin between A and B on a tie),
// further coins on the granted slot accumulate credit, and once the credit
// reaches PRICE the motor is asked to dispense. A session that sees no coin
// for TIMEOUT consecutive cycles is aborted and its credit is refunded.
// Every coin that cannot be accepted is bounced back with a one-cycle reject
// pulse on its own slot.
//
// Parameters
//   PRICE       item price in 25p units
//   STOCK_INIT  item count loaded at reset (4-bit)
//   TIMEOUT     idle cycles tolerated in COLLECT before refund (4-bit, >= 1)
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   money_a, money_b    coin code per slot: 00 none, 01 25p, 10 50p, 11 invalid
//   vend_ack            dispenser done, one-cycle pulse (ignored outside VEND)
//   grant_a, grant_b    slot owning the current session (never both)
//   reject_a, reject_b  one-cycle pulse, coin returned to that slot
//   vend_req            dispense request, held until vend_ack
//   product             one-cycle pulse, item delivered
//   change              returned amount (25p units) during product/refund, else 0
//   refund              one-cycle pulse, session aborted and credit returned
//   credit              current session credit (25p units)
//   stock               items remaining (saturates at 0)
//   sold_out            high when stock == 0
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module vend_arbiter #(
  parameter int PRICE      = 3,
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] money_a,
  input  logic [1:0] money_b,
  input  logic       vend_ack,
  output logic       grant_a,
  output logic       grant_b,
  output logic       reject_a,
  output logic       reject_b,
  output logic       vend_req,
  output logic       product,
  output logic [1:0] change,
  output logic       refund,
  output logic [2:0] credit,
  output logic [3:0] stock,
  output logic       sold_out
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_REFUND  = 2'd3;

  localparam logic [3:0] PRICE_W   = 4'(PRICE);
  localparam logic [2:0] PRICE_C   = 3'(PRICE);
  localparam logic [3:0] STOCK_RST = 4'(STOCK_INIT);
  localparam logic [3:0] IDLE_LAST = 4'(TIMEOUT - 1);

  // The coin codes 01/10 already equal their value in 25p units; anything
  // else (none or invalid) is worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    return (code == 2'b01 || code == 2'b10) ? code : 2'b00;
  endfunction

  logic [1:0] state, state_d;
  logic       ptr, ptr_d;          // round-robin tie winner: 0 = A, 1 = B
  logic [3:0] idle_cnt, idle_d;

  logic       grant_a_d, grant_b_d, reject_a_d, reject_b_d;
  logic       vend_req_d, product_d, refund_d, sold_out_d;
  logic [1:0] change_d;
  logic [2:0] credit_d;
  logic [3:0] stock_d;

  logic [1:0] val_a, val_b, own_val, start_val;
  logic       valid_a, valid_b, bad_a, bad_b, any_a, any_b;
  logic       take_a, take_b;
  logic [3:0] sum;

  assign val_a   = coin_value(money_a);
  assign val_b   = coin_value(money_b);
  assign valid_a = (val_a != 2'b00);
  assign valid_b = (val_b != 2'b00);
  assign bad_a   = (money_a == 2'b11);
  assign bad_b   = (money_b == 2'b11);
  assign any_a   = (money_a != 2'b00);
  assign any_b   = (money_b != 2'b00);

  // Session start in IDLE: a lone valid coin wins outright; on a tie the
  // round-robin pointer picks the winner.
  assign take_a    = valid_a && (!valid_b || !ptr);
  assign take_b    = valid_b && !take_a;
  assign start_val = take_a ? val_a : val_b;

  assign own_val = grant_a ? val_a : val_b;
  assign sum     = {1'b0, credit} + {2'b00, own_val};

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    state_d    = state;
    ptr_d      = ptr;
    idle_d     = idle_cnt;
    grant_a_d  = grant_a;
    grant_b_d  = grant_b;
    vend_req_d = vend_req;
    credit_d   = credit;
    stock_d    = stock;
    reject_a_d = 1'b0;
    reject_b_d = 1'b0;
    product_d  = 1'b0;
    refund_d   = 1'b0;
    change_d   = 2'b00;

    case (state)
      S_IDLE: begin
        if (sold_out) begin
          // No new session can open without stock: bounce every coin.
          reject_a_d = any_a;
          reject_b_d = any_b;
        end else begin
          reject_a_d = any_a && !take_a;
          reject_b_d = any_b && !take_b;
          if (take_a || take_b) begin
            grant_a_d = take_a;
            grant_b_d = take_b;
            credit_d  = {1'b0, start_val};
            idle_d    = 4'd0;
            // A single coin can already cover a low PRICE; go straight to
            // the motor instead of waiting in COLLECT for a coin never needed.
            if ({2'b00, start_val} >= PRICE_W) begin
              state_d    = S_VEND;
              vend_req_d = 1'b1;
            end else begin
              state_d = S_COLLECT;
            end
          end
        end
      end

      S_COLLECT: begin
        reject_a_d = grant_a ? bad_a : any_a;
        reject_b_d = grant_b ? bad_b : any_b;
        if (own_val != 2'b00) begin
          credit_d = sum[2:0];
          idle_d   = 4'd0;
          if (sum >= PRICE_W) begin
            state_d    = S_VEND;
            vend_req_d = 1'b1;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          // Refund outputs are set on entry so the pulse covers the single
          // REFUND cycle.
          state_d   = S_REFUND;
          refund_d  = 1'b1;
          change_d  = credit[1:0];
          credit_d  = 3'd0;
          grant_a_d = 1'b0;
          grant_b_d = 1'b0;
          idle_d    = 4'd0;
        end else begin
          idle_d = idle_cnt + 4'd1;
        end
      end

      S_VEND: begin
        reject_a_d = any_a;
        reject_b_d = any_b;
        if (vend_ack) begin
          state_d    = S_IDLE;
          product_d  = 1'b1;
          change_d   = 2'(credit - PRICE_C);
          credit_d   = 3'd0;
          stock_d    = (stock != 4'd0) ? stock - 4'd1 : 4'd0;
          vend_req_d = 1'b0;
          grant_a_d  = 1'b0;
          grant_b_d  = 1'b0;
          ptr_d      = ~ptr;
        end
      end

      default: begin  // S_REFUND
        reject_a_d = any_a;
        reject_b_d = any_b;
        state_d    = S_IDLE;
      end
    endcase

    sold_out_d = (stock_d == 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      idle_cnt <= 4'd0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
      reject_a <= 1'b0;
      reject_b <= 1'b0;
      vend_req <= 1'b0;
      product  <= 1'b0;
      change   <= 2'b00;
      refund   <= 1'b0;
      credit   <= 3'd0;
      stock    <= STOCK_RST;
      sold_out <= (STOCK_RST == 4'd0);
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state    <= state_d;
      ptr      <= ptr_d;
      idle_cnt <= idle_d;
      grant_a  <= grant_a_d;
      grant_b  <= grant_b_d;
      reject_a <= reject_a_d;
      reject_b <= reject_b_d;
      vend_req <= vend_req_d;
      product  <= product_d;
      change   <= change_d;
      refund   <= refund_d;
      credit   <= credit_d;
      stock    <= stock_d;
      sold_out <= sold_out_d;
    end
  end

endmodule

// File: tb/tb_vend_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vend_arbiter
//
// Self-checking bench for vend_arbiter. A behavioural session model (owner
// slot, credit, stock, motor-wait and refund flags held as plain integers)
// predicts every registered output after each clock edge. Directed scenarios
// cover the named use cases; a second instance with STOCK_INIT=1 covers the
// sold-out path; a randomized phase with varying coin density follows.
// -----------------------------------------------------------------------------
module tb_vend_arbiter;

  localparam int PRICE   = 3;
  localparam int STOCK   = 8;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] money_a, money_b;
  logic       vend_ack;

  logic       grant_a, grant_b, reject_a, reject_b, vend_req, product, refund, sold_out;
  logic [1:0] change;
  logic [2:0] credit;
  logic [3:0] stock;

  logic       d1_grant_a, d1_grant_b, d1_reject_a, d1_reject_b, d1_vend_req;
  logic       d1_product, d1_refund, d1_sold_out;
  logic [1:0] d1_change;
  logic [2:0] d1_credit;
  logic [3:0] d1_stock;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vend_arbiter #(.PRICE(PRICE), .STOCK_INIT(STOCK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .money_a(money_a), .money_b(money_b), .vend_ack(vend_ack),
    .grant_a(grant_a), .grant_b(grant_b), .reject_a(reject_a), .reject_b(reject_b),
    .vend_req(vend_req), .product(product), .change(change), .refund(refund),
    .credit(credit), .stock(stock), .sold_out(sold_out)
  );

  vend_arbiter #(.PRICE(PRICE), .STOCK_INIT(1), .TIMEOUT(TIMEOUT)) dut1 (
    .clk(clk), .rst(rst), .money_a(money_a), .money_b(money_b), .vend_ack(vend_ack),
    .grant_a(d1_grant_a), .grant_b(d1_grant_b), .reject_a(d1_reject_a), .reject_b(d1_reject_b),
    .vend_req(d1_vend_req), .product(d1_product), .change(d1_change), .refund(d1_refund),
    .credit(d1_credit), .stock(d1_stock), .sold_out(d1_sold_out)
  );

  // ---------------------------------------------------------------- model
  int m_owner;   // -1 no session, 0 slot A, 1 slot B
  int m_credit;
  int m_stock;
  int m_ptr;     // slot that wins a tie
  int m_motor;   // waiting for vend_ack
  int m_refund;  // in the single refund cycle
  int m_idle;
  int e_rej[2];
  int e_prod, e_ref, e_chg;

  task automatic model_reset();
    m_owner = -1; m_credit = 0; m_stock = STOCK; m_ptr = 0;
    m_motor = 0; m_refund = 0; m_idle = 0;
    e_rej[0] = 0; e_rej[1] = 0; e_prod = 0; e_ref = 0; e_chg = 0;
  endtask

  task automatic model_step(input logic [1:0] a, input logic [1:0] b, input logic k);
    logic [1:0] c[2];
    int v[2];
    int win;
    c[0] = a; c[1] = b;
    for (int i = 0; i < 2; i++) begin
      v[i] = (c[i] == 2'b01) ? 1 : (c[i] == 2'b10) ? 2 : 0;
      e_rej[i] = 0;
    end
    e_prod = 0; e_ref = 0; e_chg = 0;

    if (m_refund != 0) begin
      for (int i = 0; i < 2; i++) e_rej[i] = (c[i] != 2'b00);
      m_refund = 0;
    end else if (m_motor != 0) begin
      for (int i = 0; i < 2; i++) e_rej[i] = (c[i] != 2'b00);
      if (k) begin
        e_prod = 1; e_chg = m_credit - PRICE; m_credit = 0;
        if (m_stock > 0) m_stock--;
        m_owner = -1; m_motor = 0; m_ptr = 1 - m_ptr;
      end
    end else if (m_owner < 0) begin
      if (m_stock == 0) begin
        for (int i = 0; i < 2; i++) e_rej[i] = (c[i] != 2'b00);
      end else begin
        for (int i = 0; i < 2; i++) e_rej[i] = (c[i] == 2'b11);
        win = -1;
        if (v[0] > 0 && v[1] > 0) begin
          win = m_ptr;
          e_rej[1 - m_ptr] = 1;
        end else if (v[0] > 0) win = 0;
        else if (v[1] > 0) win = 1;
        if (win >= 0) begin
          m_owner = win; m_credit = v[win]; m_idle = 0;
          m_motor = (m_credit >= PRICE);
        end
      end
    end else begin
      for (int i = 0; i < 2; i++)
        e_rej[i] = (i != m_owner) ? (c[i] != 2'b00) : (c[i] == 2'b11);
      if (v[m_owner] > 0) begin
        m_credit += v[m_owner]; m_idle = 0;
        if (m_credit >= PRICE) m_motor = 1;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          e_ref = 1; e_chg = m_credit; m_credit = 0;
          m_owner = -1; m_refund = 1; m_idle = 0;
        end
      end
    end
  endtask

  function automatic logic [16:0] expected_vec();
    return {m_owner == 0, m_owner == 1, e_rej[0] != 0, e_rej[1] != 0, m_motor != 0,
            e_prod != 0, 2'(e_chg), e_ref != 0, 3'(m_credit), 4'(m_stock), m_stock == 0};
  endfunction

  function automatic logic [16:0] observed_vec();
    return {grant_a, grant_b, reject_a, reject_b, vend_req, product, change,
            refund, credit, stock, sold_out};
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, compare
  // all outputs with the model, then return at the next falling edge.
  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic k);
    money_a = a; money_b = b; vend_ack = k;
    @(posedge clk);
    model_step(a, b, k);
    #1;
    check("outputs", 32'(observed_vec()), 32'(expected_vec()));
    @(negedge clk);
  endtask

  // Asynchronous reset asserted `pre` time units after a falling edge and
  // checked before any clock edge can act; released at the next falling edge.
  task automatic do_reset(input int pre);
    #pre;
    rst = 1'b0;
    money_a = 2'b00; money_b = 2'b00; vend_ack = 1'b0;
    #1;
    model_reset();
    check("async_reset", 32'(observed_vec()), 32'(expected_vec()));
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [1:0] rnd_coin(input int density);
    if ($urandom_range(0, 99) < density) return 2'($urandom_range(1, 3));
    return 2'b00;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    int dens_tab[4];
    int dens;
    dens_tab[0] = 0; dens_tab[1] = 6; dens_tab[2] = 25; dens_tab[3] = 60;

    rst = 1'b0; money_a = 2'b00; money_b = 2'b00; vend_ack = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_state", 32'(observed_vec()), 32'(expected_vec()));
    check("reset_stock_init1", 32'({d1_stock, d1_sold_out}), 32'({4'd1, 1'b0}));
    rst = 1'b1;

    // A: 25p, 50p -> vend_req; ack -> product, change 0, stock 7, grant_a low
    step(2'b01, 2'b00, 1'b0);
    check("a_grant", 32'(grant_a), 32'd1);
    step(2'b10, 2'b00, 1'b0);
    check("a_vend_req", 32'({vend_req, credit}), 32'({1'b1, 3'd3}));
    step(2'b00, 2'b00, 1'b1);
    check("a_product", 32'({product, change, stock, grant_a}), 32'({1'b1, 2'd0, 4'd7, 1'b0}));

    // B: 50p, 50p -> ack -> product, change 1, credit 0
    step(2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b10, 1'b0);
    check("b_vend_req", 32'({vend_req, grant_b, credit}), 32'({1'b1, 1'b1, 3'd4}));
    step(2'b00, 2'b00, 1'b1);
    check("b_product", 32'({product, change, credit}), 32'({1'b1, 2'd1, 3'd0}));
    step(2'b00, 2'b00, 1'b0);
    check("b_pulse_end", 32'({product, change}), 32'd0);

    // Tie after reset goes to A; after a vend the next tie goes to B
    do_reset(0);
    step(2'b10, 2'b10, 1'b0);
    check("tie1", 32'({grant_a, grant_b, reject_a, reject_b}), 32'(4'b1001));
    step(2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    step(2'b10, 2'b10, 1'b0);
    check("tie2", 32'({grant_a, grant_b, reject_a, reject_b}), 32'(4'b0110));
    step(2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b1);

    // A: 25p then TIMEOUT idle cycles -> refund of 1, stock unchanged
    step(2'b01, 2'b00, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(2'b00, 2'b00, 1'b0);
    check("no_early_refund", 32'({refund, grant_a}), 32'({1'b0, 1'b1}));
    step(2'b00, 2'b00, 1'b0);
    check("refund", 32'({refund, change, credit, stock, grant_a}),
          32'({1'b1, 2'd1, 3'd0, 4'd6, 1'b0}));
    step(2'b00, 2'b00, 1'b0);
    check("refund_pulse_end", 32'({refund, change}), 32'd0);

    // Invalid code in IDLE is rejected and no session opens
    step(2'b11, 2'b00, 1'b0);
    check("invalid_a", 32'({reject_a, grant_a, credit}), 32'({1'b1, 1'b0, 3'd0}));
    step(2'b00, 2'b00, 1'b0);
    check("invalid_idle", 32'({reject_a, grant_a}), 32'd0);

    // STOCK_INIT=1 instance: one sale, then sold out rejects a new coin
    do_reset(0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    check("d1_vend_req", 32'(d1_vend_req), 32'd1);
    step(2'b00, 2'b00, 1'b1);
    check("d1_sold", 32'({d1_product, d1_stock, d1_sold_out}), 32'({1'b1, 4'd0, 1'b1}));
    step(2'b01, 2'b00, 1'b0);
    check("d1_sold_out_reject", 32'({d1_reject_a, d1_grant_a, d1_credit}),
          32'({1'b1, 1'b0, 3'd0}));

    // Reset mid-cycle during VEND with credit 3
    do_reset(0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    check("pre_reset_vend", 32'({vend_req, credit}), 32'({1'b1, 3'd3}));
    do_reset(2);
    check("reset_in_vend", 32'({vend_req, credit, stock, product, change}),
          32'({1'b0, 3'd0, 4'd8, 1'b0, 2'd0}));

    // Randomized traffic with varying coin density and rare resets
    for (int seg = 0; seg < 20; seg++) begin
      dens = dens_tab[$urandom_range(0, 3)];
      for (int n = 0; n < 100; n++) begin
        if ($urandom_range(0, 299) == 0) do_reset(0);
        else step(rnd_coin(dens), rnd_coin(dens), $urandom_range(0, 99) < 30);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
